keypad_scanner: RTL and testbench

Drives a 4x4 membrane keypad matrix: strobes one column low at a time, samples the row lines, and filters the result at scan level. Emits a 4-bit key code with a one-cycle valid strobe per accepted press. Sits between the keypad pins and the key-handling logic, and is the active (driving) end of the matrix interface.

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_scanner_if.sv | 27 ++
 rtl/keypad_scan_filter.sv | 118 +++++++++++
 rtl/keypad_scanner.sv | 122 ++++++++++++
 tb/tb_keypad_scanner.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/keypad_pkg.sv
// Shared types and sizes for the 4x4 keypad scanner and its scan-level filter.
package keypad_pkg;

    localparam int N_ROWS = 4;
    localparam int N_COLS = 4;
    localparam int KEY_W  = 4;
    localparam int ROW_W  = $clog2(N_ROWS);
    localparam int COL_W  = $clog2(N_COLS);

    typedef enum logic [1:0] {
        SCAN_NONE,
        SCAN_KEY,
        SCAN_MULTI
    } scan_res_e;

    typedef enum logic [1:0] {
        ST_DRIVE,
        ST_SAMPLE,
        ST_NEXT,
        ST_EVAL
    } col_state_e;

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pin side (rows/cols) plus the accepted-key output toward key-handling logic.
interface keypad_scanner_if;
    import keypad_pkg::*;

    logic [N_ROWS-1:0] i_rows;
    logic [N_COLS-1:0] o_cols;
    logic [KEY_W-1:0]  o_key;
    logic              o_valid;
    logic              o_pressed;

    modport master (
        input  i_rows,
        output o_cols,
        output o_key,
        output o_valid,
        output o_pressed
    );

    modport slave (
        output i_rows,
        input  o_cols,
        input  o_key,
        input  o_valid,
        input  o_pressed
    );

endinterface

// File: rtl/keypad_scan_filter.sv
// Scan-level debounce: stability counter, accepted key state and, with
// KEYPAD_AUTOREPEAT_EN defined, auto-repeat of the held key.
module keypad_scan_filter
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 50,
    parameter int REPEAT_RATE_SCANS  = 10
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             eval_i,
    input  scan_res_e        result_i,
    input  logic [KEY_W-1:0] code_i,
    output logic [KEY_W-1:0] key_o,
    output logic             valid_o,
    output logic             pressed_o
);

    localparam int                STAB_W   = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_SCANS);

    scan_res_e         prev_res_q, prev_res_d;
    logic [KEY_W-1:0]  prev_code_q, prev_code_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [KEY_W-1:0]  key_q, key_d;
    logic              pressed_q, pressed_d;
    logic              valid_q, valid_d;
    logic              same, accept_key, accept_none, repeat_fire;

    // A MULTI scan breaks any run, so the next clean scan always restarts at 1.
    always_comb begin
        prev_res_d  = prev_res_q;
        prev_code_d = prev_code_q;
        stab_d      = stab_q;
        accept_key  = 1'b0;
        accept_none = 1'b0;
        same        = (result_i == prev_res_q) &&
                      (result_i != SCAN_KEY || code_i == prev_code_q);
        if (eval_i) begin
            prev_res_d  = result_i;
            prev_code_d = code_i;
            if (result_i == SCAN_MULTI) begin
                stab_d = '0;
            end else begin
                if (!same)                   stab_d = STAB_W'(1);
                else if (stab_q != STAB_MAX) stab_d = stab_q + STAB_W'(1);
                if (stab_d == STAB_MAX) begin
                    accept_key  = (result_i == SCAN_KEY) && (!pressed_q || code_i != key_q);
                    accept_none = (result_i == SCAN_NONE) && pressed_q;
                end
            end
        end
    end

    always_comb begin
        key_d     = accept_key ? code_i : key_q;
        pressed_d = accept_key ? 1'b1 : (accept_none ? 1'b0 : pressed_q);
        valid_d   = accept_key | repeat_fire;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            prev_res_q  <= SCAN_NONE;
            prev_code_q <= '0;
            stab_q      <= '0;
            key_q       <= '0;
            pressed_q   <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            prev_res_q  <= prev_res_d;
            prev_code_q <= prev_code_d;
            stab_q      <= stab_d;
            key_q       <= key_d;
            pressed_q   <= pressed_d;
            valid_q     <= valid_d;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int               REP_W     = $clog2(REPEAT_DELAY_SCANS + REPEAT_RATE_SCANS + 1);
    localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY_SCANS);
    localparam logic [REP_W-1:0] REP_WRAP  = REP_W'(REPEAT_DELAY_SCANS + REPEAT_RATE_SCANS);

    logic [REP_W-1:0] rep_q, rep_d;

    // Counts scans since acceptance; folds back to the first-repeat point after each later repeat.
    always_comb begin
        rep_d       = rep_q;
        repeat_fire = 1'b0;
        if (accept_key || accept_none) begin
            rep_d = '0;
        end else if (eval_i && pressed_q) begin
            rep_d = rep_q + REP_W'(1);
            if (rep_d == REP_FIRST) begin
                repeat_fire = 1'b1;
            end else if (rep_d == REP_WRAP) begin
                repeat_fire = 1'b1;
                rep_d       = REP_FIRST;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rep_q <= '0;
        else       rep_q <= rep_d;
    end
`else
    logic unused_repeat_cfg;
    assign repeat_fire       = 1'b0;
    assign unused_repeat_cfg = ^{REPEAT_DELAY_SCANS, REPEAT_RATE_SCANS};
`endif

    assign key_o     = key_q;
    assign valid_o   = valid_q;
    assign pressed_o = pressed_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with synchronized row sampling and scan-level debounce.
// Optional auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES      = 500,
    parameter int DEBOUNCE_SCANS     = 4,
    parameter int REPEAT_DELAY_SCANS = 50,
    parameter int REPEAT_RATE_SCANS  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    keypad_scanner_if.master  kp
);

    localparam int                  SETTLE_W    = $clog2(SETTLE_CYCLES);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 3);

    logic [N_ROWS-1:0]   rows_meta_q, rows_sync_q;
    col_state_e          state_q, state_d;
    logic [COL_W-1:0]    col_q;
    logic [SETTLE_W-1:0] settle_q;
    scan_res_e           acc_q, acc_d;
    logic [KEY_W-1:0]    code_q, code_d;
    logic                sample_en, next_en, eval_en;
    logic [2:0]          col_hits;
    logic [ROW_W-1:0]    row_idx;

    // NOTE: sequential state always uses non-blocking assignment so every flop
    // samples the pre-edge values regardless of process ordering.
    // Synchronizer flops reset to the idle (pulled-up) row level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rows_meta_q <= '1;
            rows_sync_q <= '1;
        end else begin
            rows_meta_q <= kp.i_rows;
            rows_sync_q <= rows_meta_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= ST_DRIVE;
        else       state_q <= state_d;
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    // A column slot is DRIVE (SETTLE_CYCLES-2) + SAMPLE + NEXT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_DRIVE:  if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = ST_NEXT;
            ST_NEXT:   state_d = (col_q == COL_W'(N_COLS - 1)) ? ST_EVAL : ST_DRIVE;
            ST_EVAL:   state_d = ST_DRIVE;
            default:   state_d = ST_DRIVE;
        endcase
    end

    always_comb begin
        sample_en = (state_q == ST_SAMPLE);
        next_en   = (state_q == ST_NEXT);
        eval_en   = (state_q == ST_EVAL);
        kp.o_cols = ~(N_COLS'(1) << col_q);
    end

    // Fold each column's rows into the running scan result: first single hit is a KEY, anything more is MULTI.
    always_comb begin
        col_hits = '0;
        row_idx  = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (!rows_sync_q[r]) begin
                col_hits = col_hits + 3'd1;
                row_idx  = ROW_W'(r);
            end
        end
        acc_d  = acc_q;
        code_d = code_q;
        if (col_hits != 3'd0) begin
            if (acc_q == SCAN_NONE && col_hits == 3'd1) begin
                acc_d  = SCAN_KEY;
                code_d = {row_idx, col_q};
            end else begin
                acc_d = SCAN_MULTI;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            col_q    <= '0;
            settle_q <= '0;
            acc_q    <= SCAN_NONE;
            code_q   <= '0;
        end else begin
            settle_q <= (state_q == ST_DRIVE) ? settle_q + SETTLE_W'(1) : '0;
            if (next_en) col_q <= col_q + COL_W'(1);
            if (sample_en) begin
                acc_q  <= acc_d;
                code_q <= code_d;
            end else if (eval_en) begin
                acc_q <= SCAN_NONE;
            end
        end
    end

    keypad_scan_filter #(
        .DEBOUNCE_SCANS     (DEBOUNCE_SCANS),
        .REPEAT_DELAY_SCANS (REPEAT_DELAY_SCANS),
        .REPEAT_RATE_SCANS  (REPEAT_RATE_SCANS)
    ) u_filter (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .eval_i    (eval_en),
        .result_i  (acc_q),
        .code_i    (code_q),
        .key_o     (kp.o_key),
        .valid_o   (kp.o_valid),
        .pressed_o (kp.o_pressed)
    );

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model plus a scan-level reference model.
module tb_keypad_scanner;

    localparam int SETTLE = 8;
    localparam int DEB    = 3;
    localparam int RDLY   = 4;
    localparam int RRATE  = 2;
    localparam int PERIOD = 4 * SETTLE + 1;
    localparam int R_NONE  = 16;
    localparam int R_MULTI = 17;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] keys_down = '0;
    logic [3:0]  row_v;

    int n_tests = 0;
    int n_fail  = 0;

    int hist[$];
    int m_key;
    bit m_pressed;
    int scan_n;
    int acc_scan;

    keypad_scanner_if kp();

    keypad_scanner #(
        .SETTLE_CYCLES      (SETTLE),
        .DEBOUNCE_SCANS     (DEB),
        .REPEAT_DELAY_SCANS (RDLY),
        .REPEAT_RATE_SCANS  (RRATE)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .kp    (kp)
    );

    always #5 clk = ~clk;

    // Closed contact at (row r, col c) pulls row r low while column c is driven low.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_v[r] = 1'b1;
            for (int c = 0; c < 4; c++)
                if (keys_down[r*4+c] && !kp.o_cols[c]) row_v[r] = 1'b0;
        end
    end
    assign kp.i_rows = row_v;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (scan %0d, t=%0t)", tag, got, exp, scan_n, $time);
        end
    endtask

    function automatic logic [3:0] exp_cols(input int k);
        int col;
        logic [3:0] one;
        one = 4'b0001;
        col = (k >= 4 * SETTLE) ? 0 : k / SETTLE;
        return ~(one << col);
    endfunction

    function automatic int classify(input logic [15:0] m);
        int n;
        n = $countones(m);
        if (n == 0) return R_NONE;
        if (n > 1)  return R_MULTI;
        for (int i = 0; i < 16; i++) if (m[i]) return i;
        return R_NONE;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_key     = 0;
        m_pressed = 0;
        acc_scan  = 0;
    endtask

    // Accept when the last DEB scan results agree, are not MULTI, and differ from the held state.
    task automatic model_eval(input logic [15:0] m, output bit exp_valid);
        int v;
        bit all_eq;
        v = classify(m);
        exp_valid = 0;
        hist.push_back(v);
        if (hist.size() > DEB) void'(hist.pop_front());
        all_eq = (hist.size() == DEB) && (v != R_MULTI);
        foreach (hist[i]) if (hist[i] != v) all_eq = 0;
        if (all_eq && v < 16 && (!m_pressed || m_key != v)) begin
            m_key     = v;
            m_pressed = 1;
            exp_valid = 1;
            acc_scan  = scan_n;
        end else if (all_eq && v == R_NONE && m_pressed) begin
            m_pressed = 0;
        end
`ifdef KEYPAD_AUTOREPEAT_EN
        else if (m_pressed) begin
            int d;
            d = scan_n - acc_scan;
            if (d == RDLY || (d > RDLY && (d - RDLY) % RRATE == 0)) exp_valid = 1;
        end
`endif
        scan_n++;
    endtask

    // One full scan period with contacts m; rst_at >= 0 asserts reset inside that cycle and aborts the scan.
    task automatic run_scan(input logic [15:0] m, input int rst_at);
        bit ev;
        keys_down = m;
        for (int k = 0; k < PERIOD; k++) begin
            check("cols", kp.o_cols, exp_cols(k));
            if (k == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("rst_cols", kp.o_cols, 4'b1110);
                check("rst_valid", kp.o_valid, 1'b0);
                check("rst_pressed", kp.o_pressed, 1'b0);
                check("rst_key", kp.o_key, 4'h0);
                model_reset();
                @(posedge clk);
                @(posedge clk);
                #1 rst = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (k < PERIOD - 1) check("valid_idle", kp.o_valid, 1'b0);
        end
        model_eval(m, ev);
        check("valid", kp.o_valid, ev);
        check("pressed", kp.o_pressed, m_pressed);
        check("key", kp.o_key, m_key[3:0]);
    endtask

    task automatic hold(input logic [15:0] m, input int n);
        for (int i = 0; i < n; i++) run_scan(m, -1);
    endtask

    initial begin
        logic [15:0] m;
        int kind, a, b, len;
        scan_n = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_cols", kp.o_cols, 4'b1110);
        check("reset_valid", kp.o_valid, 1'b0);
        check("reset_pressed", kp.o_pressed, 1'b0);
        check("reset_key", kp.o_key, 4'h0);

        hold(16'h0000, 3);
        hold(16'h0200, 6);
        hold(16'h0000, 5);
        for (int i = 0; i < 8; i++) run_scan((i % 2 == 0) ? 16'h0200 : 16'h0000, -1);
        hold(16'h0000, 2);
        hold(16'h0200, 4);
        hold(16'h0208, 5);
        hold(16'h0200, 2);
        hold(16'h0020, 4);
        hold(16'h0000, 4);

        hold(16'h0200, 4);
        run_scan(16'h0200, 12);
        hold(16'h0200, 4);
        hold(16'h0000, 4);

        hold(16'h0200, DEB + 14);
        hold(16'h0000, 4);

        for (int seg = 0; seg < 25; seg++) begin
            kind = int'($urandom_range(0, 3));
            a    = int'($urandom_range(0, 15));
            b    = (a + 1 + int'($urandom_range(0, 14))) % 16;
            len  = int'($urandom_range(1, 5));
            m    = '0;
            if (kind == 1 || kind == 2) m[a] = 1'b1;
            if (kind == 3) begin
                m[a] = 1'b1;
                m[b] = 1'b1;
            end
            hold(m, len);
        end
        hold(16'h0000, DEB + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
